// File: rtl/pci_tx_pkg.sv
// ============================================================================
// pci_tx_pkg : shared types and defaults for the TX virtual-channel datapath
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package pci_tx_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int CRED_W_DEF = 4;
  // Destination select is the MSB of a default-width word
  localparam int DEST_BIT   = DATA_W_DEF - 1;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/vc_credit_counter.sv
// ============================================================================
// vc_credit_counter : per-destination credit counter with sticky overflow flag
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module vc_credit_counter
  import pci_tx_pkg::*;
#(
  parameter int CRED_W      = CRED_W_DEF,
  parameter int MAX_CREDITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dec,
  input  logic              inc,
  output logic [CRED_W-1:0] count,
  output logic              ovf
);

  localparam logic [CRED_W-1:0] MAX_C = CRED_W'(MAX_CREDITS);

  logic [CRED_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;

  // A simultaneous take and return cancel out, so neither can overflow
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = MAX_C;
    end else if (inc && !dec) begin
      if (count_q == MAX_C) ovf_d = 1'b1;
      else                  count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/vc_credit_scheduler.sv
// ============================================================================
// vc_credit_scheduler : credit-based WRR scheduler, VC0/VC1 -> D0/D1
// Optional grant statistics enabled by defining SCHED_STATS_EN.
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module vc_credit_scheduler
  import pci_tx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CRED_W     = CRED_W_DEF,
  parameter int D_CREDITS  = 8,
  parameter int VC0_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [DATA_W-1:0] VC0,
  input  logic [DATA_W-1:0] VC1,
  input  logic              VC0_empty,
  input  logic              VC1_empty,
  input  logic              D0_credit_ret,
  input  logic              D1_credit_ret,
  output logic              VC0_pop,
  output logic              VC1_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              D0_push,
  output logic              D1_push,
  output logic [CRED_W-1:0] D0_credits,
  output logic [CRED_W-1:0] D1_credits,
  output logic              cred_err,
  output logic [7:0]        VC0_grants,
  output logic [7:0]        VC1_grants
);

  localparam int                DSEL    = DATA_W - 1;
  localparam int                WRR_W   = $clog2(VC0_WEIGHT + 1);
  localparam logic [WRR_W-1:0]  WRR_MAX = WRR_W'(VC0_WEIGHT);

  sched_state_t      state_q, state_d;
  logic [WRR_W-1:0]  wrr_q, wrr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              d0_push_q, d0_push_d;
  logic              d1_push_q, d1_push_d;

  logic [CRED_W-1:0] d0_cnt, d1_cnt;
  logic              d0_ovf, d1_ovf;
  logic              elig0, elig1, gnt0, gnt1, grant, dest;
  logic [DATA_W-1:0] word;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= INIT;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (!enable) state_d = HOLD;
      HOLD:    if (enable)  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // ---------------- FSM: grant outputs ----------------
  assign elig0 = !VC0_empty && (VC0[DSEL] ? (d1_cnt != '0) : (d0_cnt != '0));
  assign elig1 = !VC1_empty && (VC1[DSEL] ? (d1_cnt != '0) : (d0_cnt != '0));

  // Enable is also gated here so the cycle that samples enable=0 never pops
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    wrr_d = wrr_q;
    if (state_q == RUN && enable) begin
      if (elig0 && elig1) begin
        if (wrr_q < WRR_MAX) begin
          gnt0  = 1'b1;
          wrr_d = wrr_q + 1'b1;
        end else begin
          gnt1  = 1'b1;
          wrr_d = '0;
        end
      end else if (elig0) begin
        gnt0  = 1'b1;
        wrr_d = (wrr_q == WRR_MAX) ? WRR_MAX : wrr_q + 1'b1;
      end else if (elig1) begin
        gnt1  = 1'b1;
        wrr_d = '0;
      end
    end
  end

  assign VC0_pop = gnt0;
  assign VC1_pop = gnt1;

  // ---------------- Registered datapath toward destinations ----------------
  assign grant = gnt0 | gnt1;
  assign word  = gnt1 ? VC1 : VC0;
  assign dest  = word[DSEL];

  always_comb begin
    data_d    = grant ? word : data_q;
    d0_push_d = grant & ~dest;
    d1_push_d = grant &  dest;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wrr_q     <= '0;
      data_q    <= '0;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
    end else begin
      wrr_q     <= wrr_d;
      data_q    <= data_d;
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
    end
  end

  assign data_out = data_q;
  assign D0_push  = d0_push_q;
  assign D1_push  = d1_push_q;

  // ---------------- Credit tracking ----------------
  vc_credit_counter #(
    .CRED_W      (CRED_W),
    .MAX_CREDITS (D_CREDITS)
  ) u_d0_credits (
    .clk   (clk),
    .rst_n (reset_L),
    .load  (state_q == INIT),
    .dec   (grant & ~dest),
    .inc   (D0_credit_ret),
    .count (d0_cnt),
    .ovf   (d0_ovf)
  );

  vc_credit_counter #(
    .CRED_W      (CRED_W),
    .MAX_CREDITS (D_CREDITS)
  ) u_d1_credits (
    .clk   (clk),
    .rst_n (reset_L),
    .load  (state_q == INIT),
    .dec   (grant & dest),
    .inc   (D1_credit_ret),
    .count (d1_cnt),
    .ovf   (d1_ovf)
  );

  assign D0_credits = d0_cnt;
  assign D1_credits = d1_cnt;
  assign cred_err   = d0_ovf | d1_ovf;

  // ---------------- Grant statistics ----------------
`ifdef SCHED_STATS_EN
  logic [7:0] vc0_grants_q, vc0_grants_d;
  logic [7:0] vc1_grants_q, vc1_grants_d;

  always_comb begin
    vc0_grants_d = vc0_grants_q + {7'd0, gnt0};
    vc1_grants_d = vc1_grants_q + {7'd0, gnt1};
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vc0_grants_q <= '0;
      vc1_grants_q <= '0;
    end else begin
      vc0_grants_q <= vc0_grants_d;
      vc1_grants_q <= vc1_grants_d;
    end
  end

  assign VC0_grants = vc0_grants_q;
  assign VC1_grants = vc1_grants_q;
`else
  assign VC0_grants = '0;
  assign VC1_grants = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_credit_scheduler.sv
// ============================================================================
// tb_vc_credit_scheduler : vector table, directed corner cases and random
// traffic against a behavioural model of vc_credit_scheduler
// Rev 1.0                : initial release
// ============================================================================
`default_nettype none

module tb_vc_credit_scheduler;
  import pci_tx_pkg::*;

  localparam int DW = 6;
  localparam int CW = 4;
  localparam int DC = 8;
  localparam int WT = 3;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] vc0 = '0, vc1 = '0;
  logic          vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic          d0_ret = 1'b0, d1_ret = 1'b0;

  logic          VC0_pop, VC1_pop, D0_push, D1_push, cred_err;
  logic [DW-1:0] data_out;
  logic [CW-1:0] D0_credits, D1_credits;
  logic [7:0]    VC0_grants, VC1_grants;

  always #5 clk = ~clk;

  vc_credit_scheduler #(
    .DATA_W(DW), .CRED_W(CW), .D_CREDITS(DC), .VC0_WEIGHT(WT)
  ) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .VC0(vc0), .VC1(vc1), .VC0_empty(vc0_empty), .VC1_empty(vc1_empty),
    .D0_credit_ret(d0_ret), .D1_credit_ret(d1_ret),
    .VC0_pop(VC0_pop), .VC1_pop(VC1_pop), .data_out(data_out),
    .D0_push(D0_push), .D1_push(D1_push),
    .D0_credits(D0_credits), .D1_credits(D1_credits), .cred_err(cred_err),
    .VC0_grants(VC0_grants), .VC1_grants(VC1_grants)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- Behavioural model ----------------
  bit          m_live, m_run, m_err, m_push0, m_push1;
  int          m_cred[2];
  int          m_wrr;
  int          m_g[2];
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_live = 0; m_run = 0; m_err = 0; m_push0 = 0; m_push1 = 0;
    m_cred = '{0, 0}; m_wrr = 0; m_g = '{0, 0}; m_data = '0;
  endtask

  function automatic bit elig(input int n);
    logic [DW-1:0] w;
    bit e;
    w = (n != 0) ? vc1 : vc0;
    e = (n != 0) ? vc1_empty : vc0_empty;
    return !e && (m_cred[int'(w[DEST_BIT])] > 0);
  endfunction

  function automatic int model_pick();
    if (!(m_live && m_run && enable)) return -1;
    if (elig(0) && elig(1)) return (m_wrr < WT) ? 0 : 1;
    if (elig(0)) return 0;
    if (elig(1)) return 1;
    return -1;
  endfunction

  task automatic model_edge();
    int gv, dst;
    int delta[2];
    bit ret[2];
    logic [DW-1:0] w;
    gv = model_pick();
    if (!m_live) begin
      m_live = 1; m_run = 1; m_cred = '{DC, DC}; m_push0 = 0; m_push1 = 0;
      return;
    end
    delta = '{0, 0};
    m_push0 = 0; m_push1 = 0;
    if (gv >= 0) begin
      w = (gv != 0) ? vc1 : vc0;
      dst = int'(w[DEST_BIT]);
      delta[dst] = -1;
      if (dst != 0) m_push1 = 1; else m_push0 = 1;
      m_data = w;
      m_g[gv] = (m_g[gv] + 1) % 256;
      m_wrr = (gv != 0) ? 0 : ((m_wrr < WT) ? m_wrr + 1 : WT);
    end
    ret = '{d0_ret, d1_ret};
    for (int d = 0; d < 2; d++) begin
      if (ret[d]) begin
        if (delta[d] < 0)        delta[d] = 0;
        else if (m_cred[d] == DC) m_err = 1;
        else                      delta[d] = 1;
      end
      m_cred[d] += delta[d];
    end
    m_run = enable;
  endtask

  // Compare every output against the model, then advance one clock
  task automatic step(input string tag);
    int gv;
    #1;
    gv = model_pick();
    chk({tag, " VC0_pop"},    VC0_pop,    gv == 0);
    chk({tag, " VC1_pop"},    VC1_pop,    gv == 1);
    chk({tag, " D0_push"},    D0_push,    m_push0);
    chk({tag, " D1_push"},    D1_push,    m_push1);
    chk({tag, " data_out"},   data_out,   m_data);
    chk({tag, " D0_credits"}, D0_credits, m_cred[0]);
    chk({tag, " D1_credits"}, D1_credits, m_cred[1]);
    chk({tag, " cred_err"},   cred_err,   m_err);
`ifdef SCHED_STATS_EN
    chk({tag, " VC0_grants"}, VC0_grants, m_g[0]);
    chk({tag, " VC1_grants"}, VC1_grants, m_g[1]);
`else
    chk({tag, " VC0_grants"}, VC0_grants, 0);
    chk({tag, " VC1_grants"}, VC1_grants, 0);
`endif
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    vc0_empty = 1'b1; vc1_empty = 1'b1; d0_ret = 1'b0; d1_ret = 1'b0; enable = 1'b1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  typedef struct {
    logic          en, e0, e1, r0, r1;
    logic [DW-1:0] v0, v1;
    logic          p0, p1, push0, push1;
    logic [DW-1:0] dout;
    logic [CW-1:0] c0, c1;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en   e0   e1   r0   r1   v0     v1     p0 p1 pu0 pu1 dout   c0 c1
    tbl[0] = '{1'b1,1'b1,1'b1,1'b0,1'b0,6'h00,6'h00, 1'b0,1'b0,1'b0,1'b0,6'h00,4'd8,4'd8};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b0,1'b0,6'h03,6'h00, 1'b1,1'b0,1'b1,1'b0,6'h03,4'd7,4'd8};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,1'b0,6'h00,6'h21, 1'b0,1'b1,1'b0,1'b1,6'h21,4'd8,4'd7};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,6'h34,6'h05, 1'b1,1'b0,1'b0,1'b1,6'h34,4'd8,4'd7};
    tbl[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'h03,6'h05, 1'b0,1'b0,1'b0,1'b0,6'h00,4'd8,4'd8};
    tbl[5] = '{1'b1,1'b0,1'b1,1'b1,1'b0,6'h03,6'h00, 1'b1,1'b0,1'b1,1'b0,6'h03,4'd8,4'd8};

    // Single-cycle vectors, each from a fresh reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      step("tbl init");
      enable = tbl[i].en; vc0_empty = tbl[i].e0; vc1_empty = tbl[i].e1;
      vc0 = tbl[i].v0; vc1 = tbl[i].v1; d0_ret = tbl[i].r0; d1_ret = tbl[i].r1;
      #1;
      chk("tbl VC0_pop", VC0_pop, tbl[i].p0);
      chk("tbl VC1_pop", VC1_pop, tbl[i].p1);
      step("tbl");
      chk("tbl D0_push", D0_push, tbl[i].push0);
      chk("tbl D1_push", D1_push, tbl[i].push1);
      chk("tbl data_out", data_out, tbl[i].dout);
      chk("tbl D0_credits", D0_credits, tbl[i].c0);
      chk("tbl D1_credits", D1_credits, tbl[i].c1);
    end

    // WRR pattern with all traffic to D0 until credits run out
    do_reset();
    #1;
    chk("init D0_credits", D0_credits, 0);
    step("wrr init");
    chk("after init D0_credits", D0_credits, DC);
    chk("after init D1_credits", D1_credits, DC);
    vc0 = 6'h03; vc1 = 6'h05; vc0_empty = 1'b0; vc1_empty = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("wrr VC0_pop", VC0_pop, (i < 8) && (i % 4 != 3));
      chk("wrr VC1_pop", VC1_pop, (i < 8) && (i % 4 == 3));
      step("wrr");
    end
    chk("wrr D0_credits exhausted", D0_credits, 0);

    // D0 starved: only the D1-bound head moves until a credit returns
    vc0 = 6'b110100; vc1 = 6'b010110;
    #1; chk("starve VC0_pop", VC0_pop, 1); chk("starve VC1_pop", VC1_pop, 0);
    step("starve");
    d0_ret = 1'b1;
    #1; chk("starve ret VC1_pop", VC1_pop, 0);
    step("starve ret");
    d0_ret = 1'b0; vc0_empty = 1'b1;
    #1; chk("starve reenabled VC1_pop", VC1_pop, 1);
    step("starve after");
    idle();
    step("starve idle");

    // Simultaneous take and return, then overflow on a full counter
    do_reset();
    step("cred init");
    vc1 = 6'b100111; vc1_empty = 1'b0; d1_ret = 1'b1;
    #1; chk("cred VC1_pop", VC1_pop, 1);
    step("cred same edge");
    idle();
    chk("cred D1 unchanged", D1_credits, DC);
    chk("cred no err", cred_err, 0);
    d0_ret = 1'b1;
    step("cred ovf");
    d0_ret = 1'b0;
    chk("cred_err set", cred_err, 1);
    step("cred sticky");
    step("cred sticky");
    chk("cred_err sticky", cred_err, 1);

    // Enable dropped for two cycles mid-stream
    do_reset();
    step("hold init");
    vc0 = 6'h03; vc1 = 6'h05; vc0_empty = 1'b0; vc1_empty = 1'b0;
    step("hold pre");
    step("hold pre");
    enable = 1'b0;
    #1; chk("hold en0 VC0_pop", VC0_pop, 0); chk("hold last D0_push", D0_push, 1);
    step("hold en0");
    #1; chk("hold VC0_pop", VC0_pop, 0); chk("hold VC1_pop", VC1_pop, 0);
    step("hold");
    enable = 1'b1;
    #1; chk("hold exit VC0_pop", VC0_pop, 0); chk("hold exit VC1_pop", VC1_pop, 0);
    step("hold exit");
    #1; chk("resume VC0_pop", VC0_pop, 1);
    step("resume");
    #1; chk("resume wrr VC1_pop", VC1_pop, 1);
    step("resume");
    idle();
    step("resume idle");

    // Asynchronous reset with a push pending
    do_reset();
    step("async init");
    vc0 = 6'h03; vc0_empty = 1'b0;
    step("async pop");
    chk("async pending D0_push", D0_push, 1);
    idle();
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    chk("async D0_push", D0_push, 0);
    chk("async data_out", data_out, 0);
    chk("async D0_credits", D0_credits, 0);
    chk("async D1_credits", D1_credits, 0);
    chk("async VC0_pop", VC0_pop, 0);
    chk("async VC1_pop", VC1_pop, 0);
    chk("async cred_err", cred_err, 0);
    chk("async VC0_grants", VC0_grants, 0);
    chk("async VC1_grants", VC1_grants, 0);
    @(negedge clk);
    reset_L = 1'b1;
    step("async reinit");
    step("async idle");

    // Random traffic against the model
    do_reset();
    step("rand init");
    for (int i = 0; i < 400; i++) begin
      vc0 = DW'($urandom);
      vc1 = DW'($urandom);
      vc0_empty = ($urandom % 4) == 0;
      vc1_empty = ($urandom % 4) == 0;
      enable    = ($urandom % 8) != 0;
      d0_ret    = ($urandom % 4) == 0;
      d1_ret    = ($urandom % 4) == 0;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
